// File: rtl/servo_steer_sequencer.sv
// ============================================================================
// Module   : servo_steer_sequencer
// Brief    : Frame-synchronous obstacle-avoidance steering sequencer for an RC
//            servo; emits one registered pulse-width command per servo frame.
// Revision : 1.0
// ============================================================================
`default_nettype none

module servo_steer_sequencer #(
    parameter int unsigned FRAME_CYCLES  = 1000000,
    parameter int unsigned NEAR_THRESH   = 350000,
    parameter int unsigned CENTER_W      = 30500,
    parameter int unsigned AVOID_W       = 24500,
    parameter int unsigned RETURN_W      = 37000,
    parameter int unsigned DEBOUNCE      = 2,
    parameter int unsigned MAX_AVOID     = 12,
    parameter int unsigned SETTLE_FRAMES = 3,
    parameter int unsigned STALE_FRAMES  = 4
) (
    input  logic        osc,
    input  logic        reset,
    input  logic        enable,
    input  logic        echo_valid,
    input  logic [31:0] echo_cnt,
    output logic [31:0] pulse_width,
    output logic        frame_start,
    output logic [1:0]  steer_state,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_CENTER = 2'd0,
        ST_AVOID  = 2'd1,
        ST_RETURN = 2'd2,
        ST_SETTLE = 2'd3
    } state_t;

    localparam logic [31:0] C_LAST     = 32'(FRAME_CYCLES - 1);
    localparam logic [31:0] C_NEAR     = 32'(NEAR_THRESH);
    localparam logic [31:0] C_CENTER_W = 32'(CENTER_W);
    localparam logic [31:0] C_AVOID_W  = 32'(AVOID_W);
    localparam logic [31:0] C_RETURN_W = 32'(RETURN_W);
    localparam logic [3:0]  C_DEBOUNCE = 4'(DEBOUNCE);
    localparam logic [7:0]  C_MAX      = 8'(MAX_AVOID);
    localparam logic [7:0]  C_SETTLE   = 8'(SETTLE_FRAMES);
    localparam logic [31:0] C_STALE    = 32'(STALE_FRAMES);

    state_t      r_state, w_state_nxt;
    logic [31:0] r_frame_cnt;
    logic        r_frame_start;
    logic [31:0] r_pulse_width, w_pw_nxt;
    logic        r_near_q;
    logic [31:0] r_stale_cnt;
    logic [3:0]  r_deb_cnt, w_deb_nxt;
    logic [7:0]  r_avoid_cnt, w_avoid_nxt;
    logic [7:0]  r_ret_cnt, w_ret_nxt;
    logic [7:0]  r_set_cnt, w_set_nxt;
    logic        w_boundary, w_cmp_near, w_near_now;

    assign w_boundary = (r_frame_cnt == C_LAST);
    assign w_cmp_near = (echo_cnt < C_NEAR);
    // A strobe landing in the boundary cycle still belongs to the ending frame.
    assign w_near_now = echo_valid ? w_cmp_near : r_near_q;

    // Frame timebase and echo tracking run regardless of enable.
    always_ff @(posedge osc) begin
        if (reset) begin
            r_frame_cnt   <= '0;
            r_frame_start <= 1'b0;
            r_near_q      <= 1'b0;
            r_stale_cnt   <= '0;
        end else begin
            r_frame_cnt   <= w_boundary ? '0 : r_frame_cnt + 32'd1;
            r_frame_start <= w_boundary;
            if (echo_valid) begin
                r_near_q    <= w_cmp_near;
                r_stale_cnt <= '0;
            end else if (w_boundary) begin
                if (r_stale_cnt + 32'd1 < C_STALE) begin
                    r_stale_cnt <= r_stale_cnt + 32'd1;
                end else begin
                    r_stale_cnt <= C_STALE;
                    r_near_q    <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge osc) begin
        if (reset) begin
            r_state       <= ST_CENTER;
            r_deb_cnt     <= '0;
            r_avoid_cnt   <= '0;
            r_ret_cnt     <= '0;
            r_set_cnt     <= '0;
            r_pulse_width <= C_CENTER_W;
        end else begin
            r_state       <= w_state_nxt;
            r_deb_cnt     <= w_deb_nxt;
            r_avoid_cnt   <= w_avoid_nxt;
            r_ret_cnt     <= w_ret_nxt;
            r_set_cnt     <= w_set_nxt;
            r_pulse_width <= w_pw_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_deb_nxt   = r_deb_cnt;
        w_avoid_nxt = r_avoid_cnt;
        w_ret_nxt   = r_ret_cnt;
        w_set_nxt   = r_set_cnt;
        w_pw_nxt    = r_pulse_width;
        if (w_boundary) begin
            if (!enable) begin
                w_state_nxt = ST_CENTER;
                w_deb_nxt   = '0;
                w_avoid_nxt = '0;
                w_ret_nxt   = '0;
                w_set_nxt   = '0;
            end else begin
                case (r_state)
                    ST_CENTER: begin
                        if (!w_near_now) begin
                            w_deb_nxt = '0;
                        end else if (r_deb_cnt + 4'd1 >= C_DEBOUNCE) begin
                            w_state_nxt = ST_AVOID;
                            w_avoid_nxt = 8'd1;
                            w_deb_nxt   = '0;
                        end else begin
                            w_deb_nxt = r_deb_cnt + 4'd1;
                        end
                    end
                    ST_AVOID: begin
                        if (w_near_now && (r_avoid_cnt < C_MAX)) begin
                            w_avoid_nxt = r_avoid_cnt + 8'd1;
                        end else begin
                            w_state_nxt = ST_RETURN;
                            w_ret_nxt   = r_avoid_cnt;
                        end
                    end
                    ST_RETURN: begin
                        if (w_near_now) begin
                            w_state_nxt = ST_AVOID;
                            w_avoid_nxt = 8'd1;
                        end else begin
                            w_ret_nxt = r_ret_cnt - 8'd1;
                            if (r_ret_cnt <= 8'd1) begin
                                w_state_nxt = ST_SETTLE;
                                w_set_nxt   = C_SETTLE;
                            end
                        end
                    end
                    ST_SETTLE: begin
                        w_set_nxt = r_set_cnt - 8'd1;
                        if (r_set_cnt <= 8'd1) begin
                            w_state_nxt = ST_CENTER;
                            w_deb_nxt   = '0;
                        end
                    end
                    default: w_state_nxt = ST_CENTER;
                endcase
            end
            case (w_state_nxt)
                ST_AVOID:  w_pw_nxt = C_AVOID_W;
                ST_RETURN: w_pw_nxt = C_RETURN_W;
                default:   w_pw_nxt = C_CENTER_W;
            endcase
        end
    end

    assign pulse_width = r_pulse_width;
    assign frame_start = r_frame_start;
    assign steer_state = r_state;
    assign busy        = (r_state != ST_CENTER);

endmodule

`default_nettype wire
